truth_table_sweeper: RTL and testbench



---
 rtl/tt_pkg.sv | 27 ++
 rtl/tt_classify.sv | 37 +++
 rtl/truth_table_sweeper.sv | 136 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_pkg
// Description : Shared types and constants for the truth-table sweeper:
//               sweep state encoding, table-width helper, settle counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Settle counter width; covers SETTLE values 0..15.
    localparam int c_CNT_W = 4;

    // Number of truth-table entries for an n_in-input function.
    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_classify.sv
`default_nettype none
// ============================================================================
// Module      : tt_classify
// Description : Combinational post-processing of a captured truth table:
//               maxterm count and constant-0 / constant-1 flags. Outputs are
//               forced to zero unless the sweep has completed.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_classify
    import tt_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic                        done_state_i,
    input  logic [tt_width(N_IN)-1:0]   tt_vec_i,
    input  logic [N_IN:0]               ones_cnt_i,
    output logic [N_IN:0]               zeros_cnt_o,
    output logic                        is_const0_o,
    output logic                        is_const1_o
);

    localparam logic [N_IN:0] c_TT_CNT = (N_IN + 1)'(tt_width(N_IN));

    // Results only exist once a full table has been captured.
    always_comb begin
        zeros_cnt_o = '0;
        is_const0_o = 1'b0;
        is_const1_o = 1'b0;
        if (done_state_i) begin
            zeros_cnt_o = c_TT_CNT - ones_cnt_i;
            is_const0_o = ~|tt_vec_i;
            is_const1_o = &tt_vec_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Drives every input combination of an N_IN-input boolean
//               function in ascending order, samples its output after SETTLE
//               idle cycles, and assembles the truth table plus minterm /
//               maxterm counts and constant flags.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    output logic [N_IN-1:0]             drive,
    input  logic                        sample,
    output logic                        busy,
    output logic                        done,
    output logic [tt_width(N_IN)-1:0]   tt_vec,
    output logic [N_IN:0]               ones_cnt,
    output logic [N_IN:0]               zeros_cnt,
    output logic                        is_const0,
    output logic                        is_const1
);

    localparam int c_TT_W = tt_width(N_IN);

    // WAIT exits on the cycle the counter reads zero, so loading SETTLE-1
    // gives exactly SETTLE wait cycles. With SETTLE = 0 the WAIT state is
    // skipped entirely and each combination is a single CAPTURE cycle.
    localparam logic [c_CNT_W-1:0] c_RELOAD =
        c_CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam state_t c_ENTRY = (SETTLE == 0) ? ST_CAPTURE : ST_WAIT;

    state_t                 state_q, state_d;
    logic [N_IN-1:0]        idx_q,   idx_d;
    logic [c_CNT_W-1:0]     cnt_q,   cnt_d;
    logic [c_TT_W-1:0]      tt_q,    tt_d;
    logic [N_IN:0]          ones_q,  ones_d;
    logic                   done_q,  done_d;

    // State and datapath registers; reset clears every visible result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
        end
    end

    // Sweep sequencing: settle, capture, advance; abort wins over capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = c_ENTRY;
                    idx_d   = '0;
                    cnt_d   = c_RELOAD;
                    tt_d    = '0;
                    ones_d  = '0;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    ones_d  = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    ones_d  = '0;
                end else begin
                    tt_d[idx_q] = sample;
                    ones_d      = ones_q + (N_IN + 1)'(sample);
                    // Termination is tested before the increment so idx never wraps.
                    if (&idx_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + N_IN'(1);
                        cnt_d   = c_RELOAD;
                        state_d = c_ENTRY;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign drive    = idx_q;
    assign busy     = (state_q == ST_WAIT) || (state_q == ST_CAPTURE);
    assign done     = done_q;
    assign tt_vec   = tt_q;
    assign ones_cnt = ones_q;

    tt_classify #(
        .N_IN (N_IN)
    ) u_classify (
        .done_state_i (state_q == ST_DONE),
        .tt_vec_i     (tt_q),
        .ones_cnt_i   (ones_q),
        .zeros_cnt_o  (zeros_cnt),
        .is_const0_o  (is_const0),
        .is_const1_o  (is_const1)
    );

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Scoreboard bench for truth_table_sweeper. Two instances:
//               dut0 (N_IN=3, SETTLE=2) and dut1 (N_IN=2, SETTLE=0). The
//               function under test is a bench-held table indexed by drive.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    typedef struct {
        logic [7:0] tt;
        logic [3:0] ones;
        logic [3:0] zeros;
        logic       c0;
        logic       c1;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // dut0 signals
    logic       start0, abort0, sample0, busy0, done0, k00, k10;
    logic [2:0] drive0;
    logic [7:0] tt0, fn0;
    logic [3:0] ones0, zeros0;
    // dut1 signals
    logic       start1, abort1, sample1, busy1, done1, k01, k11;
    logic [1:0] drive1;
    logic [3:0] tt1, fn1;
    logic [2:0] ones1, zeros1;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sample0 = fn0[drive0];
    assign sample1 = fn1[drive1];

    truth_table_sweeper #(.N_IN(3), .SETTLE(2)) u_dut0 (
        .clk(clk), .reset(rst), .start(start0), .abort(abort0),
        .drive(drive0), .sample(sample0), .busy(busy0), .done(done0),
        .tt_vec(tt0), .ones_cnt(ones0), .zeros_cnt(zeros0),
        .is_const0(k00), .is_const1(k10)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(0)) u_dut1 (
        .clk(clk), .reset(rst), .start(start1), .abort(abort1),
        .drive(drive1), .sample(sample1), .busy(busy1), .done(done1),
        .tt_vec(tt1), .ones_cnt(ones1), .zeros_cnt(zeros1),
        .is_const0(k01), .is_const1(k11)
    );

    // ---------------- helpers ----------------
    function automatic int nin(int d);    return (d == 0) ? 3 : 2; endfunction
    function automatic int settle(int d); return (d == 0) ? 2 : 0; endfunction

    function automatic logic [2:0] get_drive(int d); return (d == 0) ? drive0 : {1'b0, drive1}; endfunction
    function automatic logic       get_busy(int d);  return (d == 0) ? busy0 : busy1; endfunction
    function automatic logic       get_done(int d);  return (d == 0) ? done0 : done1; endfunction
    function automatic logic [7:0] get_tt(int d);    return (d == 0) ? tt0 : {4'b0, tt1}; endfunction
    function automatic logic [3:0] get_ones(int d);  return (d == 0) ? ones0 : {1'b0, ones1}; endfunction
    function automatic logic [3:0] get_zeros(int d); return (d == 0) ? zeros0 : {1'b0, zeros1}; endfunction
    function automatic logic       get_c0(int d);    return (d == 0) ? k00 : k01; endfunction
    function automatic logic       get_c1(int d);    return (d == 0) ? k10 : k11; endfunction

    function automatic void set_start(int d, logic v); if (d == 0) start0 = v; else start1 = v; endfunction
    function automatic void set_abort(int d, logic v); if (d == 0) abort0 = v; else abort1 = v; endfunction
    function automatic void set_fn(int d, logic [7:0] v); if (d == 0) fn0 = v; else fn1 = v[3:0]; endfunction

    function automatic void push_exp(int d, exp_t e); if (d == 0) q0.push_back(e); else q1.push_back(e); endfunction
    function automatic int  q_size(int d); return (d == 0) ? q0.size() : q1.size(); endfunction
    function automatic exp_t pop_exp(int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void chk(string name, int d, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, d, got, want, $time);
        end
    endfunction

    // Reference model: a full sweep of table fnv yields fnv itself, its
    // popcount, the complement count, and the constant flags; done appears
    // 2**N*(SETTLE+1) edges after the accepting edge.
    function automatic exp_t make_exp(int d, logic [7:0] fnv, int now);
        exp_t e;
        int   w;
        int   ones;
        w    = 1 << nin(d);
        ones = 0;
        e.tt = '0;
        for (int i = 0; i < w; i++) begin
            e.tt[i] = fnv[i];
            if (fnv[i]) ones++;
        end
        e.ones  = 4'(ones);
        e.zeros = 4'(w - ones);
        e.c0    = (ones == 0);
        e.c1    = (ones == w);
        e.cyc   = now + 1 + w * (settle(d) + 1);
        return e;
    endfunction

    function automatic void chk_results(string name, int d, exp_t e);
        chk({name, "_tt"},    d, 32'(get_tt(d)),    32'(e.tt));
        chk({name, "_ones"},  d, 32'(get_ones(d)),  32'(e.ones));
        chk({name, "_zeros"}, d, 32'(get_zeros(d)), 32'(e.zeros));
        chk({name, "_c0"},    d, 32'(get_c0(d)),    32'(e.c0));
        chk({name, "_c1"},    d, 32'(get_c1(d)),    32'(e.c1));
    endfunction

    function automatic void chk_all_zero(string name, int d);
        chk({name, "_drive"}, d, 32'(get_drive(d)), 32'd0);
        chk({name, "_busy"},  d, 32'(get_busy(d)),  32'd0);
        chk({name, "_done"},  d, 32'(get_done(d)),  32'd0);
        chk({name, "_tt"},    d, 32'(get_tt(d)),    32'd0);
        chk({name, "_ones"},  d, 32'(get_ones(d)),  32'd0);
        chk({name, "_zeros"}, d, 32'(get_zeros(d)), 32'd0);
        chk({name, "_c0"},    d, 32'(get_c0(d)),    32'd0);
        chk({name, "_c1"},    d, 32'(get_c1(d)),    32'd0);
    endfunction

    // ---------------- monitor ----------------
    logic       prev_busy [2];
    logic [2:0] prev_drv  [2];
    int         hold      [2];

    always @(negedge clk) begin : mon
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                prev_busy[d] <= 1'b0;
                hold[d]      <= 0;
            end else begin
                if (get_done(d)) begin
                    if (q_size(d) == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done dut%0d: done seen, no sweep outstanding (t=%0t)", d, $time);
                    end else begin
                        e = pop_exp(d);
                        chk_results("sweep", d, e);
                        chk("latency_cycle", d, 32'(cyc), 32'(e.cyc));
                        chk("busy_in_done", d, 32'(get_busy(d)), 32'd0);
                    end
                end
                // drive must step by one and hold SETTLE+1 cycles per value
                if (get_busy(d) && prev_busy[d]) begin
                    if (get_drive(d) != prev_drv[d]) begin
                        chk("drive_step", d, 32'(get_drive(d)), 32'(prev_drv[d] + 3'd1));
                        chk("drive_hold", d, 32'(hold[d]), 32'(settle(d) + 1));
                        hold[d] <= 1;
                    end else begin
                        hold[d] <= hold[d] + 1;
                    end
                end else if (get_busy(d)) begin
                    hold[d] <= 1;
                end
                prev_busy[d] <= get_busy(d);
                prev_drv[d]  <= get_drive(d);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Issue start at a negedge (optionally with abort, which start must beat),
    // record the expectation, and return at the negedge after acceptance.
    task automatic launch(input int d, input logic [7:0] fnv, input bit with_abort, output exp_t e);
        set_fn(d, fnv);
        set_start(d, 1'b1);
        set_abort(d, with_abort);
        e = make_exp(d, fnv, cyc);
        push_exp(d, e);
        @(negedge clk);
        set_start(d, 1'b0);
        set_abort(d, 1'b0);
    endtask

    task automatic wait_done(input int d);
        int budget;
        budget = (1 << nin(d)) * (settle(d) + 1) + 10;
        for (int i = 0; i < budget && !get_done(d); i++) @(negedge clk);
        if (!get_done(d)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout dut%0d: no done within %0d cycles", d, budget);
        end
    endtask

    task automatic run(input int d, input logic [7:0] fnv, input bit with_abort, input bit mid_start, output exp_t e);
        int l;
        l = (1 << nin(d)) * (settle(d) + 1);
        launch(d, fnv, with_abort, e);
        if (mid_start) begin
            repeat ($urandom_range(0, l - 2)) @(negedge clk);
            set_start(d, 1'b1);
            @(negedge clk);
            set_start(d, 1'b0);
        end
        wait_done(d);
    endtask

    task automatic abort_test(input int d, input logic [7:0] fnv);
        exp_t e;
        exp_t part;
        launch(d, fnv, 1'b0, e);
        void'(pop_exp(d));                  // this sweep never completes
        for (int i = 0; i < 40 && get_drive(d) != 3'd2; i++) @(negedge clk);
        chk("abort_reach_combo2", d, 32'(get_drive(d)), 32'd2);
        set_abort(d, 1'b1);
        @(negedge clk);
        set_abort(d, 1'b0);
        part       = make_exp(d, 8'h00, cyc);
        part.tt    = fnv & 8'h03;           // combinations 0 and 1 were captured
        part.zeros = 4'd0;
        part.c0    = 1'b0;
        chk("abort_busy", d, 32'(get_busy(d)), 32'd0);
        chk("abort_done", d, 32'(get_done(d)), 32'd0);
        chk_results("abort", d, part);
        repeat (30) @(negedge clk);         // monitor flags any stray done
        chk("abort_idle_tt", d, 32'(get_tt(d)), 32'(part.tt));
    endtask

    initial begin : stim
        exp_t e;
        int   d;
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        fn0 = '0; fn1 = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset", 0);
        chk_all_zero("reset", 1);
        rst = 1'b0;
        @(negedge clk);

        // directed tables: majority, ~x0, constants
        run(0, 8'hE8, 1'b0, 1'b0, e);
        run(1, 8'h05, 1'b0, 1'b0, e);
        run(1, 8'h0F, 1'b0, 1'b0, e);
        run(1, 8'h00, 1'b0, 1'b0, e);
        run(0, 8'hFF, 1'b0, 1'b0, e);
        run(0, 8'h00, 1'b0, 1'b0, e);

        // results hold and abort is ignored once done
        @(negedge clk);
        chk("done_one_cycle", 0, 32'(get_done(0)), 32'd0);
        set_abort(0, 1'b1);
        @(negedge clk);
        set_abort(0, 1'b0);
        chk_results("abort_in_done", 0, e);

        // randomized sweeps with start+abort collisions, mid-sweep starts,
        // and restarts issued in the done cycle
        for (int i = 0; i < 12; i++) begin
            d = i % 2;
            run(d, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
            if (i % 3 == 0) begin
                launch(d, 8'($urandom), 1'b0, e);
                chk("restart_tt_clear", d, 32'(get_tt(d)), 32'd0);
                chk("restart_busy", d, 32'(get_busy(d)), 32'd1);
                chk("restart_done", d, 32'(get_done(d)), 32'd0);
                wait_done(d);
            end
            @(negedge clk);
        end

        // abort during combination 2, then a clean sweep
        abort_test(1, 8'($urandom));
        run(1, 8'($urandom), 1'b0, 1'b0, e);
        abort_test(0, 8'($urandom));
        run(0, 8'($urandom), 1'b0, 1'b0, e);
        @(negedge clk);

        // asynchronous reset between edges while dut0 sits in WAIT
        launch(0, 8'($urandom), 1'b0, e);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async_reset", 0);
        chk_all_zero("async_reset", 1);
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(0, 8'($urandom), 1'b0, 1'b0, e);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 0, 32'(q_size(0)), 32'd0);
        chk("scoreboard_drained", 1, 32'(q_size(1)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
